sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter for a single asynchronous SRAM: port 0 (fetch) and port 1 (data).
// Each access runs SETUP, ACC_CYCLES x ACCESS, HOLD; ties are resolved round-robin.
module sram_arbiter #(
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [17:0] addr0,
    input  logic [17:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic        Ram1_EN,
    output logic        Ram1_OE,
    output logic        Ram1_WE,
    output logic [17:0] Ram1_address,
    inout  wire  [15:0] Ram1_data,
    output logic        rdn,
    output logic        wrn
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_t;

    localparam logic [3:0] CntLoad = 4'(ACC_CYCLES - 1);

    state_t      state_q;
    logic        last_grant_q;
    logic        port_q;
    logic        we_q;
    logic        drive_q;
    logic [15:0] wdata_q;
    logic [3:0]  cnt_q;

    logic        grant;
    logic        g_we;
    logic [17:0] g_addr;
    logic [15:0] g_wdata;

    // A lone request wins outright; on a tie the port that did not win last time goes.
    assign grant   = (req0 && req1) ? ~last_grant_q : req1;
    assign g_we    = grant ? we1 : we0;
    assign g_addr  = grant ? addr1 : addr0;
    assign g_wdata = grant ? wdata1 : wdata0;

    assign busy      = (state_q != StIdle);
    assign Ram1_data = drive_q ? wdata_q : 16'bz;
    assign rdn       = 1'b1;
    assign wrn       = 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            drive_q      <= 1'b0;
            wdata_q      <= 16'h0000;
            cnt_q        <= 4'd0;
            Ram1_EN      <= 1'b1;
            Ram1_OE      <= 1'b1;
            Ram1_WE      <= 1'b1;
            Ram1_address <= 18'h00000;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= 16'h0000;
            rdata1       <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        state_q      <= StSetup;
                        last_grant_q <= grant;
                        port_q       <= grant;
                        we_q         <= g_we;
                        wdata_q      <= g_wdata;
                        Ram1_address <= g_addr;
                        Ram1_EN      <= 1'b0;
                        Ram1_OE      <= g_we;
                        drive_q      <= g_we;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    cnt_q   <= CntLoad;
                    Ram1_WE <= ~we_q;
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StHold;
                        Ram1_OE <= 1'b1;
                        Ram1_WE <= 1'b1;
                        ack0    <= ~port_q;
                        ack1    <= port_q;
                        // Read data is sampled while OE is still low, on the last ACCESS edge.
                        if (!we_q) begin
                            if (port_q) begin
                                rdata1 <= Ram1_data;
                            end else begin
                                rdata0 <= Ram1_data;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StHold: begin
                    state_q <= StIdle;
                    Ram1_EN <= 1'b1;
                    drive_q <= 1'b0;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (ACC_CYCLES 2 and 1) checked every cycle against
// a model that tracks each access as a cycle offset from its grant, plus directed checks.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [17:0] addr0 [2], addr1 [2];
    logic [15:0] wdata0 [2], wdata1 [2];
    logic        ack0 [2], ack1 [2], busy [2];
    logic [15:0] rdata0 [2], rdata1 [2];
    logic        en [2], oe [2], wen [2], rdn [2], wrn [2];
    logic [17:0] ram_addr [2];
    wire  [15:0] bus_obs [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    int grant_log [$];

    function automatic int acc_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [15:0] init_val(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire  [15:0] bus;
        logic [15:0] mem [1024];

        sram_arbiter #(.ACC_CYCLES((g == 0) ? 2 : 1)) u_dut (
            .CLK         (clk),
            .RST         (rst[g]),
            .req0        (req0[g]),
            .req1        (req1[g]),
            .we0         (we0[g]),
            .we1         (we1[g]),
            .addr0       (addr0[g]),
            .addr1       (addr1[g]),
            .wdata0      (wdata0[g]),
            .wdata1      (wdata1[g]),
            .ack0        (ack0[g]),
            .ack1        (ack1[g]),
            .rdata0      (rdata0[g]),
            .rdata1      (rdata1[g]),
            .busy        (busy[g]),
            .Ram1_EN     (en[g]),
            .Ram1_OE     (oe[g]),
            .Ram1_WE     (wen[g]),
            .Ram1_address(ram_addr[g]),
            .Ram1_data   (bus),
            .rdn         (rdn[g]),
            .wrn         (wrn[g])
        );

        // Undriven bus floats to all ones so a stray driver shows up as a value.
        for (genvar b = 0; b < 16; b++) begin : g_pu
            pullup u_pu (bus[b]);
        end

        assign bus = (!en[g] && !oe[g]) ? mem[ram_addr[g][9:0]] : 16'bz;
        assign bus_obs[g] = bus;

        initial for (int a = 0; a < 1024; a++) mem[a] = init_val(a);

        always @(negedge clk) if (!en[g] && !wen[g]) mem[ram_addr[g][9:0]] = bus;
    end

    // Model: m_t is the cycle offset since grant (0 idle, 1 setup, 2..A+1 strobe, A+2 ack).
    int          m_t [2];
    bit          m_port [2], m_we [2], m_last [2];
    bit   [17:0] m_addr [2];
    bit   [15:0] m_wdata [2], m_rd0 [2], m_rd1 [2];
    bit   [15:0] m_mem [2][1024];

    initial for (int i = 0; i < 2; i++) for (int a = 0; a < 1024; a++) m_mem[i][a] = init_val(a);

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_t[i] = 0; m_last[i] = 1'b1; m_rd0[i] = '0; m_rd1[i] = '0; m_addr[i] = '0;
            end else if (m_t[i] == 0) begin
                if (req0[i] || req1[i]) begin
                    m_port[i]  = (req0[i] && req1[i]) ? !m_last[i] : req1[i];
                    m_last[i]  = m_port[i];
                    m_we[i]    = m_port[i] ? we1[i] : we0[i];
                    m_addr[i]  = m_port[i] ? addr1[i] : addr0[i];
                    m_wdata[i] = m_port[i] ? wdata1[i] : wdata0[i];
                    m_t[i]     = 1;
                    if (i == 0) grant_log.push_back(int'(m_port[i]));
                end
            end else if (m_t[i] == acc_of(i) + 2) begin
                m_t[i] = 0;
            end else begin
                if (m_t[i] == acc_of(i) + 1) begin
                    if (m_we[i]) m_mem[i][m_addr[i][9:0]] = m_wdata[i];
                    else if (m_port[i]) m_rd1[i] = m_mem[i][m_addr[i][9:0]];
                    else m_rd0[i] = m_mem[i][m_addr[i][9:0]];
                end
                m_t[i]++;
            end
        end
    end

    task automatic chk(input int i, input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got 0x%0h, want 0x%0h", name, i, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int t, a;
                bit act, rd_ph, wr_ph;
                logic [15:0] bus_exp;
                t = m_t[i];
                a = acc_of(i);
                act   = (t > 0);
                rd_ph = act && !m_we[i] && (t <= a + 1);
                wr_ph = act && m_we[i] && (t >= 2) && (t <= a + 1);
                if (act && m_we[i]) bus_exp = m_wdata[i];
                else if (rd_ph) bus_exp = m_mem[i][m_addr[i][9:0]];
                else bus_exp = 16'hFFFF;
                chk(i, "EN", 32'(en[i]), 32'(!act));
                chk(i, "OE", 32'(oe[i]), 32'(!rd_ph));
                chk(i, "WE", 32'(wen[i]), 32'(!wr_ph));
                chk(i, "ACK0", 32'(ack0[i]), 32'(t == a + 2 && !m_port[i]));
                chk(i, "ACK1", 32'(ack1[i]), 32'(t == a + 2 && m_port[i]));
                chk(i, "BUSY", 32'(busy[i]), 32'(act));
                chk(i, "BUS", 32'(bus_obs[i]), 32'(bus_exp));
                chk(i, "RDATA0", 32'(rdata0[i]), 32'(m_rd0[i]));
                chk(i, "RDATA1", 32'(rdata1[i]), 32'(m_rd1[i]));
                chk(i, "RDN_WRN", 32'({rdn[i], wrn[i]}), 32'd3);
                if (act) chk(i, "ADDR", 32'(ram_addr[i]), 32'(m_addr[i]));
            end
        end
    end

    // Strobe counts cover the cycles before the ack cycle (SETUP through last ACCESS).
    task automatic access(input int i, input bit p, input bit w, input logic [17:0] a,
                          input logic [15:0] d, output int lat, output int en_n,
                          output int oe_n, output int we_n, output int drv_n,
                          output logic [15:0] rd, output int ack_at);
        int start;
        bit seen;
        start = cyc; seen = 1'b0; lat = -1; ack_at = -1; rd = '0;
        en_n = 0; oe_n = 0; we_n = 0; drv_n = 0;
        if (p) begin
            req1[i] = 1'b1; we1[i] = w; addr1[i] = a; wdata1[i] = d;
        end else begin
            req0[i] = 1'b1; we0[i] = w; addr0[i] = a; wdata0[i] = d;
        end
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if ((p ? ack1[i] : ack0[i]) == 1'b1) begin
                seen = 1'b1; lat = cyc - start; ack_at = cyc;
                rd = p ? rdata1[i] : rdata0[i];
            end else begin
                if (!en[i]) en_n++;
                if (!oe[i]) oe_n++;
                if (!wen[i]) we_n++;
                if (w && bus_obs[i] == d) drv_n++;
            end
        end
        chk(i, "ack_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req0[i] = 1'b0; req1[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, en_n, oe_n, we_n, drv_n, ack_at, prev;
        logic [15:0] rd;
        int order [$];
        bit overlap, late_ack;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req0[i] = 1'b0; req1[i] = 1'b0; we0[i] = 1'b0; we1[i] = 1'b0;
            addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0; chk_en = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(i, "rst_EN", 32'(en[i]), 32'd1);
            chk(i, "rst_OE", 32'(oe[i]), 32'd1);
            chk(i, "rst_WE", 32'(wen[i]), 32'd1);
            chk(i, "rst_ADDR", 32'(ram_addr[i]), 32'd0);
            chk(i, "rst_ACK", 32'({ack0[i], ack1[i]}), 32'd0);
            chk(i, "rst_RDATA", 32'({rdata0[i], rdata1[i]}), 32'd0);
            chk(i, "rst_BUSY", 32'(busy[i]), 32'd0);
            chk(i, "rst_BUS", 32'(bus_obs[i]), 32'hFFFF);
        end
        @(posedge clk); #1;

        // Single write then read-back, ACC_CYCLES=2.
        access(0, 1'b1, 1'b1, 18'h00010, 16'hA5A5, lat, en_n, oe_n, we_n, drv_n, rd, ack_at);
        chk(0, "w_latency", lat, 4);
        chk(0, "w_en_low", en_n, 3);
        chk(0, "w_we_low", we_n, 2);
        chk(0, "w_bus_driven", drv_n, 3);
        chk(0, "w_oe_low", oe_n, 0);
        access(0, 1'b0, 1'b0, 18'h00010, 16'h0000, lat, en_n, oe_n, we_n, drv_n, rd, ack_at);
        chk(0, "r_latency", lat, 4);
        chk(0, "r_oe_low", oe_n, 3);
        chk(0, "r_we_low", we_n, 0);
        chk(0, "r_rdata", 32'(rd), 32'hA5A5);

        // Contention from reset: both requests held high.
        grant_log.delete();
        rst[0] = 1'b1;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 18'h00020;
        req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 18'h00030; wdata1[0] = 16'h1234;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        overlap = 1'b0;
        for (int n = 0; n < 60 && order.size() < 4; n++) begin
            @(negedge clk);
            if (ack0[0] && ack1[0]) overlap = 1'b1;
            if (ack0[0]) order.push_back(0);
            if (ack1[0]) order.push_back(1);
        end
        @(posedge clk); #1;
        req0[0] = 1'b0; req1[0] = 1'b0;
        chk(0, "cont_ack_count", order.size(), 4);
        chk(0, "cont_overlap", 32'(overlap), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk(0, "cont_ack_order", (k < order.size()) ? order[k] : 9, k % 2);
            chk(0, "cont_model_grant", (k < grant_log.size()) ? grant_log[k] : 9, k % 2);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset during the first ACCESS cycle of a write.
        req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 18'h00040; wdata1[0] = 16'hBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk(0, "mid_we_low", 32'(wen[0]), 32'd0);
        rst[0] = 1'b1; req1[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk(0, "abort_strobes", 32'({en[0], oe[0], wen[0]}), 32'd7);
        chk(0, "abort_bus", 32'(bus_obs[0]), 32'hFFFF);
        chk(0, "abort_busy", 32'(busy[0]), 32'd0);
        late_ack = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (ack0[0] || ack1[0]) late_ack = 1'b1;
            @(negedge clk);
        end
        chk(0, "abort_no_ack", 32'(late_ack), 32'd0);
        @(posedge clk); #1;
        access(0, 1'b1, 1'b1, 18'h00050, 16'h7777, lat, en_n, oe_n, we_n, drv_n, rd, ack_at);
        chk(0, "post_rst_w_latency", lat, 4);
        access(0, 1'b0, 1'b0, 18'h00050, 16'h0000, lat, en_n, oe_n, we_n, drv_n, rd, ack_at);
        chk(0, "post_rst_rdata", 32'(rd), 32'h7777);

        // ACC_CYCLES=1: ten writes then ten reads, back to back.
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            access(1, 1'b1, 1'b1, 18'(k), 16'(k + 256), lat, en_n, oe_n, we_n, drv_n, rd, ack_at);
            chk(1, "a1_w_latency", lat, 3);
            chk(1, "a1_w_we_low", we_n, 1);
            if (k > 0) chk(1, "a1_w_interval", ack_at - prev, 4);
            prev = ack_at;
        end
        for (int k = 0; k < 10; k++) begin
            access(1, 1'b0, 1'b0, 18'(k), 16'h0000, lat, en_n, oe_n, we_n, drv_n, rd, ack_at);
            chk(1, "a1_r_latency", lat, 3);
            chk(1, "a1_r_rdata", 32'(rd), 32'(k + 256));
            chk(1, "a1_r_interval", ack_at - prev, 4);
            prev = ack_at;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
